// File: rtl/dct_block_arbiter.sv
// dct_block_arbiter: shares one block-level 8x8 DCT core between NUM_REQ
// block sources. Round-robin picks a requester into a one-block staging
// register; a tag FIFO remembers who owns each block in the core so the
// in-order results route back to the right requester.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_data    per-requester block input (slice r = requester r)
//   core_in_valid/ready/data        staged block to the DCT core (registered)
//   core_out_valid/ready/data       result stream from the core (in order)
//   rsp_valid/rsp_ready/rsp_data    one-hot result delivery; data is a broadcast
//   inflight                        blocks staged plus blocks inside the core
//   err_orphan                      sticky: a result arrived with no tag
module dct_block_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*64*DATA_W-1:0]  req_data,
    output logic                          core_in_valid,
    input  logic                          core_in_ready,
    output logic [64*DATA_W-1:0]          core_in_data,
    input  logic                          core_out_valid,
    output logic                          core_out_ready,
    input  logic [64*DATA_W-1:0]          core_out_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [64*DATA_W-1:0]          rsp_data,
    output logic [$clog2(TAG_DEPTH):0]    inflight,
    output logic                          err_orphan
);

    localparam int unsigned BLK_W = 64 * DATA_W;
    localparam int unsigned TAG_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    stage_t             state_q, state_d;
    logic [BLK_W-1:0]   stage_data_q;
    logic [TAG_W-1:0]   stage_tag_q;
    logic [TAG_W-1:0]   rr_q;
    logic [TAG_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;
    logic               err_q;

    logic               fifo_empty;
    logic               core_accept;
    logic               pop;
    logic               load;
    logic               win_found;
    logic [TAG_W-1:0]   win_idx;
    logic [TAG_W-1:0]   search_idx;
    logic [TAG_W-1:0]   head_tag;
    logic [CNT_W-1:0]   inflight_c;
    logic [CNT_W-1:0]   inflight_after;

    // Tag FIFO status and output-side routing
    assign fifo_empty     = (fifo_cnt_q == '0);
    assign head_tag       = tag_mem[rd_ptr_q];
    assign core_accept    = (state_q == ST_FULL) && core_in_ready;
    // With no tag outstanding the core is drained so a stray result cannot stall it
    assign core_out_ready = fifo_empty ? 1'b1 : rsp_ready[head_tag];
    assign pop            = core_out_valid && core_out_ready && !fifo_empty;
    assign inflight_c     = fifo_cnt_q + CNT_W'(state_q == ST_FULL);
    // A same-cycle pop frees a slot for a same-cycle load
    assign inflight_after = inflight_c - CNT_W'(pop);

    // Round-robin search starting at rr_q, wrapping at NUM_REQ
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        search_idx = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            search_idx = TAG_W'((int'(rr_q) + i) % int'(NUM_REQ));
            if (!win_found && req_valid[search_idx]) begin
                win_found = 1'b1;
                win_idx   = search_idx;
            end
        end
    end

    assign load = ((state_q == ST_EMPTY) || core_accept) &&
                  (inflight_after < CNT_W'(TAG_DEPTH)) && win_found;

    // Grant is one-hot on the winner only when the load actually happens
    always_comb begin
        req_ready = '0;
        if (load) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (!fifo_empty) begin
            rsp_valid[head_tag] = core_out_valid;
        end
    end

    // Staging FSM: next state
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_FULL;
        end else if (core_accept) begin
            state_d = ST_EMPTY;
        end
    end

    // Staging FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Staged block, its tag and the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_data_q <= '0;
            stage_tag_q  <= '0;
            rr_q         <= '0;
        end else if (load) begin
            stage_data_q <= req_data[int'(win_idx)*BLK_W +: BLK_W];
            stage_tag_q  <= win_idx;
            rr_q         <= (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + TAG_W'(1);
        end
    end

    // Tag FIFO: push on core accept, pop on result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_mem[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (core_accept) begin
                tag_mem[wr_ptr_q] <= stage_tag_q;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({core_accept, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Sticky orphan flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (core_out_valid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign core_in_valid = (state_q == ST_FULL);
    assign core_in_data  = stage_data_q;
    assign rsp_data      = core_out_data;
    assign inflight      = inflight_c;
    assign err_orphan    = err_q;

endmodule

// File: tb/tb_dct_block_arbiter.sv
// tb_dct_block_arbiter: directed self-checking bench for dct_block_arbiter.
// A small in-order core model (result = bitwise inverse of the block,
// fixed latency) sits on the core side; tasks drive each scenario.
module tb_dct_block_arbiter;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned TAG_DEPTH = 4;
    localparam int unsigned BLK_W     = 64 * DATA_W;
    localparam int unsigned CNT_W     = $clog2(TAG_DEPTH) + 1;
    localparam int          LAT       = 5;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*BLK_W-1:0]   req_data = '0;
    logic                       core_in_valid;
    logic                       core_in_ready = 1'b1;
    logic [BLK_W-1:0]           core_in_data;
    logic                       core_out_valid;
    logic                       core_out_ready;
    logic [BLK_W-1:0]           core_out_data;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready = '1;
    logic [BLK_W-1:0]           rsp_data;
    logic [CNT_W-1:0]           inflight;
    logic                       err_orphan;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dct_block_arbiter #(
        .DATA_W    (DATA_W),
        .NUM_REQ   (NUM_REQ),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .core_in_data   (core_in_data),
        .core_out_valid (core_out_valid),
        .core_out_ready (core_out_ready),
        .core_out_data  (core_out_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .inflight       (inflight),
        .err_orphan     (err_orphan)
    );

    // Core model: in-order, fixed latency, result = ~block; cleared by reset
    logic [BLK_W-1:0] q_blk [$];
    int               q_due [$];
    int               cyc;
    logic             m_valid;
    logic [BLK_W-1:0] m_data;
    logic             model_en  = 1'b1;
    logic             man_valid = 1'b0;

    assign core_out_valid = model_en ? m_valid : man_valid;
    assign core_out_data  = m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_blk.delete();
            q_due.delete();
            cyc = 0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (core_in_valid && core_in_ready) begin
                q_blk.push_back(~core_in_data);
                q_due.push_back(cyc + LAT);
            end
            if (model_en && m_valid && core_out_ready) begin
                void'(q_blk.pop_front());
                void'(q_due.pop_front());
            end
            cyc++;
            if (q_blk.size() > 0 && q_due[0] <= cyc) begin
                m_valid <= 1'b1;
                m_data  <= q_blk[0];
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    function automatic logic [BLK_W-1:0] mk_blk(input logic [31:0] base, input logic [31:0] step);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < 64; i++) begin
            b[i*DATA_W +: DATA_W] = base + step * 32'(i);
        end
        return b;
    endfunction

    task automatic set_req(input int r, input logic [BLK_W-1:0] b);
        req_data[r*BLK_W +: BLK_W] = b;
    endtask

    task automatic do_reset();
        req_valid     = '0;
        req_data      = '0;
        core_in_ready = 1'b1;
        rsp_ready     = '1;
        model_en      = 1'b1;
        man_valid     = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL reset_core_in_valid got=%b want=0", core_in_valid); end
        checks++; if (core_in_data !== '0) begin errors++; $display("FAIL reset_core_in_data low=%h want=0", core_in_data[63:0]); end
        checks++; if (inflight !== '0) begin errors++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan got=%b want=0", err_orphan); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=000", rsp_valid); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b want=000", req_ready); end
    endtask

    task automatic test_single();
        logic [BLK_W-1:0] ramp;
        bit got;
        do_reset();
        ramp = mk_blk(32'h0, 32'h0001_0000);
        set_req(1, ramp);
        req_valid = 3'b010;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_req_ready got=%b want=010", req_ready); end
        @(posedge clk); #1;
        checks++; if (core_in_valid !== 1'b1) begin errors++; $display("FAIL single_core_in_valid got=%b want=1", core_in_valid); end
        checks++; if (core_in_data !== ramp) begin errors++; $display("FAIL single_core_in_data low=%h want=%h", core_in_data[63:0], ramp[63:0]); end
        checks++; if (inflight !== CNT_W'(1)) begin errors++; $display("FAIL single_inflight got=%0d want=1", inflight); end
        @(negedge clk);
        req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk); #1;
            if (rsp_valid !== '0) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL single_rsp_timeout got=none want=response"); end
        checks++; if (rsp_valid !== 3'b010) begin errors++; $display("FAIL single_rsp_valid got=%b want=010", rsp_valid); end
        checks++; if (rsp_data !== ~ramp) begin errors++; $display("FAIL single_rsp_data low=%h want=%h", rsp_data[63:0], ~ramp[63:0]); end
        @(posedge clk); #1;
        checks++; if (inflight !== '0) begin errors++; $display("FAIL single_inflight_end got=%0d want=0", inflight); end
    endtask

    task automatic test_round_robin();
        logic [BLK_W-1:0] blks [NUM_REQ];
        logic [NUM_REQ-1:0] exp_oh;
        int ng, nr;
        do_reset();
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            blks[r] = mk_blk(32'hA000_0000 + (32'(r) << 16), 32'h1);
            set_req(r, blks[r]);
        end
        req_valid = '1;
        ng = 0;
        nr = 0;
        for (int k = 0; k < 80 && (ng < 6 || nr < 6); k++) begin
            if (ng >= 6) req_valid = '0;
            #1;
            if (req_ready !== '0) begin
                exp_oh = 3'b001 << (ng % 3);
                checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant%0d got=%b want=%b", ng, req_ready, exp_oh); end
                ng++;
            end
            if (rsp_valid !== '0) begin
                exp_oh = 3'b001 << (nr % 3);
                checks++; if (rsp_valid !== exp_oh || rsp_data !== ~blks[nr % 3]) begin
                    errors++; $display("FAIL rr_rsp%0d valid=%b want=%b data_low=%h want=%h", nr, rsp_valid, exp_oh, rsp_data[63:0], ~blks[nr % 3][63:0]);
                end
                nr++;
            end
            @(negedge clk);
        end
        checks++; if (ng != 6 || nr != 6) begin errors++; $display("FAIL rr_counts grants=%0d rsps=%0d want=6/6", ng, nr); end
    endtask

    task automatic test_stall();
        logic [BLK_W-1:0] a, b, c;
        logic [BLK_W-1:0] exp_d [2];
        logic [NUM_REQ-1:0] exp_v [2];
        int nr;
        do_reset();
        a = mk_blk(32'h1111_0000, 32'h3);
        b = mk_blk(32'h2222_0000, 32'h5);
        c = mk_blk(32'h3333_0000, 32'h7);
        core_in_ready = 1'b0;
        set_req(0, a);
        req_valid = 3'b001;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL stall_first_grant got=%b want=001", req_ready); end
        @(negedge clk);
        set_req(0, b);
        set_req(1, c);
        req_valid = 3'b011;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (core_in_valid !== 1'b1 || core_in_data !== a || req_ready !== '0) begin
                errors++; $display("FAIL stall_hold%0d valid=%b data_low=%h want=%h req_ready=%b want=000", k, core_in_valid, core_in_data[63:0], a[63:0], req_ready);
            end
            @(negedge clk);
        end
        core_in_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL stall_release_grant got=%b want=010", req_ready); end
        @(posedge clk); #1;
        checks++; if (core_in_data !== c) begin errors++; $display("FAIL stall_next_data low=%h want=%h", core_in_data[63:0], c[63:0]); end
        @(negedge clk);
        req_valid = '0;
        exp_d[0] = ~a; exp_v[0] = 3'b001;
        exp_d[1] = ~c; exp_v[1] = 3'b010;
        nr = 0;
        for (int k = 0; k < 40 && nr < 2; k++) begin
            #1;
            if (rsp_valid !== '0) begin
                checks++; if (rsp_valid !== exp_v[nr] || rsp_data !== exp_d[nr]) begin
                    errors++; $display("FAIL stall_rsp%0d valid=%b want=%b data_low=%h want=%h", nr, rsp_valid, exp_v[nr], rsp_data[63:0], exp_d[nr][63:0]);
                end
                nr++;
            end
            @(negedge clk);
        end
        checks++; if (nr != 2) begin errors++; $display("FAIL stall_rsp_count got=%0d want=2", nr); end
    endtask

    task automatic test_full();
        int ng;
        bit done;
        do_reset();
        rsp_ready = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) set_req(r, mk_blk(32'hC000_0000 + 32'(r), 32'h10));
        req_valid = '1;
        ng = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready !== '0) ng++;
            @(negedge clk);
        end
        #1;
        checks++; if (ng != 4) begin errors++; $display("FAIL full_grants got=%0d want=4", ng); end
        checks++; if (inflight !== CNT_W'(4)) begin errors++; $display("FAIL full_inflight got=%0d want=4", inflight); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL full_req_ready got=%b want=000", req_ready); end
        checks++; if (rsp_valid !== 3'b001 || core_out_ready !== 1'b0) begin errors++; $display("FAIL full_head rsp_valid=%b want=001 core_out_ready=%b want=0", rsp_valid, core_out_ready); end
        rsp_ready = 3'b001;
        #1;
        checks++; if (core_out_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%b want=1", core_out_ready); end
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL full_pop_load got=%b want=010", req_ready); end
        @(negedge clk);
        rsp_ready = '0;
        req_valid = '0;
        #1;
        checks++; if (inflight !== CNT_W'(4)) begin errors++; $display("FAIL full_after_swap got=%0d want=4", inflight); end
        rsp_ready = '1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk); #1;
            if (inflight === '0) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL full_drain inflight=%0d want=0", inflight); end
    endtask

    task automatic test_head_block();
        bit got;
        do_reset();
        rsp_ready = 3'b001;
        set_req(2, mk_blk(32'h5A5A_0000, 32'h2));
        req_valid = 3'b100;
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL head_grant got=%b want=100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk); #1;
            if (rsp_valid !== '0) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL head_rsp_timeout got=none want=response"); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (rsp_valid !== 3'b100 || core_out_ready !== 1'b0 || inflight !== CNT_W'(1)) begin
                errors++; $display("FAIL head_hold%0d rsp_valid=%b want=100 core_out_ready=%b want=0 inflight=%0d want=1", k, rsp_valid, core_out_ready, inflight);
            end
            @(negedge clk); #1;
        end
        rsp_ready = 3'b100;
        @(posedge clk); #1;
        checks++; if (inflight !== '0) begin errors++; $display("FAIL head_release inflight=%0d want=0", inflight); end
    endtask

    task automatic test_orphan_reset();
        do_reset();
        model_en  = 1'b0;
        man_valid = 1'b1;
        #1;
        checks++; if (core_out_ready !== 1'b1 || rsp_valid !== '0) begin errors++; $display("FAIL orphan_route core_out_ready=%b want=1 rsp_valid=%b want=000", core_out_ready, rsp_valid); end
        @(negedge clk);
        man_valid = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got=%b want=1", err_orphan); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got=%b want=1", err_orphan); end
        model_en  = 1'b1;
        rsp_ready = '0;
        set_req(0, mk_blk(32'h7000_0000, 32'h1));
        set_req(1, mk_blk(32'h7100_0000, 32'h1));
        req_valid = 3'b011;
        repeat (2) @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (inflight !== CNT_W'(2)) begin errors++; $display("FAIL orphan_two_inflight got=%0d want=2", inflight); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (inflight !== '0 || core_in_valid !== 1'b0 || err_orphan !== 1'b0) begin
            errors++; $display("FAIL async_reset inflight=%0d core_in_valid=%b err_orphan=%b want=0/0/0", inflight, core_in_valid, err_orphan);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = '1;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (err_orphan !== 1'b0 || inflight !== '0) begin errors++; $display("FAIL post_reset err_orphan=%b inflight=%0d want=0/0", err_orphan, inflight); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_full();
        test_head_block();
        test_orphan_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dct_block_arbiter.md
Name: dct_block_arbiter

Overview:
- Shares one 8x8 2-D Chen DCT core (block-level 64-word in/out, valid/ready) between NUM_REQ block sources, e.g. the Y, Cb and Cr tilers.
- Round-robin arbitration on the input side, with a one-block registered staging stage.
- A tag FIFO records the requester of each block in flight, so in-order core results route back to the originating requester.
- Sits between the tiler/colour-split stage and the DCT core.

Parameters:
- DATA_W, 32: word width (fixed-point, core format).
- NUM_REQ, 3: number of requesters (2..8).
- TAG_DEPTH, 4: maximum blocks in flight inside the core, including the staged block (power of 2).
- TAG_W, $clog2(NUM_REQ): derived; not overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester block valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ*64*DATA_W  requester r block in slice r; word i of block at [i*DATA_W +: DATA_W].
- core_in_valid  out  1  staged block valid to core.
- core_in_ready  in  1  core accept.
- core_in_data  out  64*DATA_W  staged block (registered).
- core_out_valid  in  1  core result valid.
- core_out_ready  out  1  result accept to core.
- core_out_data  in  64*DATA_W  core result.
- rsp_valid  out  NUM_REQ  one-hot result valid to owning requester.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  64*DATA_W  = core_out_data, combinational broadcast.
- inflight  out  $clog2(TAG_DEPTH)+1  blocks staged plus blocks in core.
- err_orphan  out  1  sticky: result arrived with no tag.

Behaviour:
- Reset (async assert, sync release): core_in_valid=0, core_in_data=0, staging empty, rr pointer=0, tag FIFO empty, inflight=0, err_orphan=0. req_ready, rsp_valid and core_out_ready follow their combinational rules below.
- Staging register states: EMPTY / FULL; core_in_valid = FULL.
- Load condition: (EMPTY or core accept this cycle) and inflight_after < TAG_DEPTH and any req_valid.
  - inflight_after = inflight minus pops this cycle.
- Load action:
  - winner = first r with req_valid, searching from rr pointer upward with wrap.
  - req_ready[winner]=1 combinationally, same cycle.
  - Block and tag registered; core_in_valid=1 next cycle.
  - rr pointer = winner+1 mod NUM_REQ.
- Request-to-core latency: 1 cycle. Back-to-back loads are allowed: accept and load in the same cycle keeps FULL, giving 1 block/cycle peak.
- Stability: while FULL and !core_in_ready, core_in_data and the tag are held unchanged; no load occurs.
- Core accept (FULL and core_in_ready): push staged tag into the tag FIFO.
- Output routing:
  - FIFO non-empty: rsp_valid[head]=core_out_valid; core_out_ready=rsp_ready[head]. Other rsp_valid bits are 0.
  - Pop on core_out_valid && core_out_ready.
- Orphan: FIFO empty and core_out_valid → core_out_ready=1, result dropped, rsp_valid=0, err_orphan set until reset.
- inflight = FIFO count + staged. Same-cycle push/pop leaves the FIFO count unchanged; load and pop are independent.
- Full: inflight==TAG_DEPTH → req_ready all 0 until a pop.
- A requester that deasserts req_valid without a handshake is simply not chosen; no state is kept.
- Reset mid-operation discards the staged block and all tags. Core results arriving after reset are orphans.

Test Plan:
- Single requester 1, block ramp 0x00010000*i, core fixed latency 5, rsp_ready=1 → core_in_valid one cycle after req handshake; rsp_valid=3'b010 with data equal to core output; inflight returns to 0.
- All three requesters valid continuously, core always ready → grant order 0,1,2,0,1,2; req_ready is one-hot each load cycle; staged tags and rsp_valid order match.
- core_in_ready held low 10 cycles with staging FULL → core_in_data and tag are bit-stable; req_ready=0 throughout; the load occurs on the release cycle.
- TAG_DEPTH=4, core_out_ready starved via rsp_ready=0 → after 4 accepted blocks inflight=4 and req_ready=0; raising rsp_ready[head] pops one and the next load occurs in the same cycle.
- Head tag=2 with rsp_ready[2]=0 and rsp_ready[0]=1 → core_out_ready=0, no pop, rsp_valid=3'b100 held.
- core_out_valid pulse with FIFO empty → core_out_ready=1 and err_orphan=1 sticky; an asynchronous rst_n pulse while 2 blocks are in flight → inflight=0, core_in_valid=0, err_orphan=0 immediately.
